cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the dcache control unit and the icache.
- Arbitrates their word requests onto the single RAM port.
- Returns load data and a per-requester wait signal. The dcache control unit advances a state whenever its dwait is low.
- Dcache has priority, bounded by an icache anti-starvation counter.

Parameters:
STARVE_MAX, 4, consecutive dcache grants allowed while an icache request waits before icache is forced through (≥1)
ADDR_W, 32, address width
DATA_W, 32, word width

Ports:
CLK  input  1  clock, all state on rising edge
nRST  input  1  asynchronous reset, active-high (nRST=1 resets immediately; nRST=0 runs)
iREN  input  1  icache read request
iaddr  input  ADDR_W  icache word address
iload  output  DATA_W  icache read data, valid when iwait=0
iwait  output  1  icache stall; low for exactly one cycle per completed icache access
dREN  input  1  dcache read request
dWEN  input  1  dcache write request
daddr  input  ADDR_W  dcache word address
dstore  input  DATA_W  dcache write data
dload  output  DATA_W  dcache read data, valid when dwait=0
dwait  output  1  dcache stall; low for exactly one cycle per completed dcache access
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  ADDR_W  RAM address
ramstore  output  DATA_W  RAM write data
ramload  input  DATA_W  RAM read data, valid with ram_ready
ram_ready  input  1  RAM completion pulse, one cycle, only while a RAM enable is high

Behaviour:
- Reset values: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- Reset also forces state=IDLE, starve_cnt=0, and clears the request latch.
- Reset asserted mid-access aborts the access; no wait-low pulse is produced.
- States: IDLE, D_ACCESS, I_ACCESS.
- IDLE:
  - RAM enables are 0; iwait=dwait=1.
  - If iREN=1 and starve_cnt==STARVE_MAX: go to I_ACCESS, latch iaddr, clear starve_cnt.
  - Else if dREN|dWEN: go to D_ACCESS, latch daddr, dstore and op. dWEN=1 selects write even if dREN=1.
  - On a D grant, starve_cnt increments (saturating at STARVE_MAX) if iREN=1 at that edge; otherwise it clears.
  - Else if iREN: go to I_ACCESS, latch iaddr, clear starve_cnt.
- D_ACCESS:
  - ramaddr and ramstore come from the latch.
  - ramWEN=1 for a write; ramREN=1 for a read; never both.
  - When ram_ready=1 in the same cycle: dwait=0 and dload=ramload (reads only; writes give dload=0). Next state is IDLE.
- I_ACCESS:
  - ramREN=1, ramaddr=latched iaddr.
  - When ram_ready=1: iwait=0 and iload=ramload. Next state is IDLE.
- Wait outputs stay 1 outside the completion cycle. The non-served requester's wait is always 1.
- Latency:
  - Request seen at edge N drives the RAM from cycle N+1.
  - Completion is in the cycle ram_ready rises, combinational to wait and load.
  - Back-to-back accesses need at least 1 IDLE cycle between them.
  - Minimum access is 2 cycles, with ram_ready asserted in the first access cycle.
- Latching and input changes:
  - Requester inputs are latched at grant. Changes to daddr, dstore or iaddr during an access are ignored.
  - A requester that drops its request mid-access still has the access completed and still receives its wait-low pulse.
- Simultaneous dcache and icache requests in IDLE: dcache wins unless the starvation limit is reached.
- ram_ready while in IDLE is ignored.
- starve_cnt has width clog2(STARVE_MAX+1) and never wraps.
- Outputs have no glitch requirement beyond synchronous correctness.

Test Plan:
- Reset: hold nRST=1 three cycles with dREN=1 → iwait=dwait=1 and all RAM outputs 0. Release; first ramREN rises one cycle later with ramaddr=daddr.
- Dcache read: daddr=0x0000_0040, RAM returns ramload=0xDEAD_BEEF after 3 busy cycles → dwait=0 for exactly one cycle with dload=0xDEAD_BEEF; iwait=1 throughout.
- Dcache write with dREN=dWEN=1, daddr=0x3100, dstore=0x0000_0007 → ramWEN=1, ramREN=0, ramstore=0x7 until ram_ready; dwait pulses low once.
- Contention: iREN and dcache requests held continuously, STARVE_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I. Icache sees iwait=0 with correct iload every fifth access.
- Input change mid-access: change daddr from 0x80 to 0x84 and drop dREN while in D_ACCESS → ramaddr stays 0x80; access completes; dwait pulses low once; next state is IDLE with no new grant.
- Reset mid-access: assert nRST during I_ACCESS before ram_ready → ramREN=0 immediately and iwait=1; after release, a fresh icache access completes normally.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: arbitrates dcache and icache word requests onto one RAM port.
// Ports: CLK/nRST, icache (iREN,iaddr,iload,iwait), dcache (dREN,dWEN,daddr,dstore,
// dload,dwait), RAM (ramREN,ramWEN,ramaddr,ramstore,ramload,ram_ready).
module cache_mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready
);

    typedef enum logic [1:0] {IDLE, D_ACCESS, I_ACCESS} state_t;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    state_t            state;
    logic [SW-1:0]     starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] store_q;
    logic              wr_q;

    logic in_d;
    logic in_i;

    assign in_d = (state == D_ACCESS);
    assign in_i = (state == I_ACCESS);

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
            store_q    <= '0;
            wr_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (iREN && starve_cnt == SMAX) begin
                        // icache has waited out STARVE_MAX dcache grants
                        state      <= I_ACCESS;
                        addr_q     <= iaddr;
                        store_q    <= '0;
                        wr_q       <= 1'b0;
                        starve_cnt <= '0;
                    end else if (dREN || dWEN) begin
                        state   <= D_ACCESS;
                        addr_q  <= daddr;
                        store_q <= dstore;
                        wr_q    <= dWEN;
                        // only count grants that actually made icache wait
                        if (!iREN)
                            starve_cnt <= '0;
                        else if (starve_cnt != SMAX)
                            starve_cnt <= starve_cnt + SW'(1);
                    end else if (iREN) begin
                        state      <= I_ACCESS;
                        addr_q     <= iaddr;
                        store_q    <= '0;
                        wr_q       <= 1'b0;
                        starve_cnt <= '0;
                    end
                end
                D_ACCESS, I_ACCESS: begin
                    if (ram_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM side decodes straight from state so an async reset drops it at once
    assign ramREN   = in_i || (in_d && !wr_q);
    assign ramWEN   = in_d && wr_q;
    assign ramaddr  = (in_d || in_i) ? addr_q : '0;
    assign ramstore = (in_d && wr_q) ? store_q : '0;

    // completion is combinational with ram_ready
    assign dwait = !(in_d && ram_ready);
    assign iwait = !(in_i && ram_ready);
    assign dload = (in_d && !wr_q && ram_ready) ? ramload : '0;
    assign iload = (in_i && ram_ready) ? ramload : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed bench for cache_mem_arbiter.
// Inputs change on falling edges; outputs sampled 1ns after.
module tb_cache_mem_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;

    int checks = 0;
    int errors = 0;

    cache_mem_arbiter #(
        .STARVE_MAX(4),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .iREN(iREN),
        .iaddr(iaddr),
        .iload(iload),
        .iwait(iwait),
        .dREN(dREN),
        .dWEN(dWEN),
        .daddr(daddr),
        .dstore(dstore),
        .dload(dload),
        .dwait(dwait),
        .ramREN(ramREN),
        .ramWEN(ramWEN),
        .ramaddr(ramaddr),
        .ramstore(ramstore),
        .ramload(ramload),
        .ram_ready(ram_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset;
        nRST = 1'b1; iREN = 1'b0; iaddr = '0;
        dREN = 1'b1; dWEN = 1'b0; daddr = 32'h10; dstore = '0;
        ramload = 32'h0; ram_ready = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL rst_iwait got=%b exp=1", iwait); end
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL rst_dwait got=%b exp=1", dwait); end
        checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL rst_en got=%b exp=00", {ramREN, ramWEN}); end
        checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL rst_ram got=%h/%h exp=0/0", ramaddr, ramstore); end
        checks++; if (iload !== 32'h0 || dload !== 32'h0) begin errors++; $display("FAIL rst_load got=%h/%h exp=0/0", iload, dload); end
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rel_idle got=%b exp=0", ramREN); end
        @(negedge CLK);
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h10) begin errors++; $display("FAIL rel_first got=%b/%h exp=1/10", ramREN, ramaddr); end
        ram_ready = 1'b1; ramload = 32'h11; dREN = 1'b0;
        #1;
        checks++; if (dwait !== 1'b0 || dload !== 32'h11) begin errors++; $display("FAIL rel_done got=%b/%h exp=0/11", dwait, dload); end
        @(negedge CLK);
        ram_ready = 1'b0;
    endtask

    task automatic test_dread;
        dREN = 1'b1; daddr = 32'h0000_0040;
        @(negedge CLK);
        repeat (3) begin
            #1;
            checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || dwait !== 1'b1 || iwait !== 1'b1)
                begin errors++; $display("FAIL dread_busy got=%b/%h/%b/%b exp=1/40/1/1", ramREN, ramaddr, dwait, iwait); end
            @(negedge CLK);
        end
        ram_ready = 1'b1; ramload = 32'hDEAD_BEEF; dREN = 1'b0;
        #1;
        checks++; if (dwait !== 1'b0 || dload !== 32'hDEAD_BEEF || iwait !== 1'b1)
            begin errors++; $display("FAIL dread_done got=%b/%h/%b exp=0/deadbeef/1", dwait, dload, iwait); end
        @(negedge CLK);
        ram_ready = 1'b0;
        #1;
        checks++; if (dwait !== 1'b1 || ramREN !== 1'b0 || dload !== 32'h0)
            begin errors++; $display("FAIL dread_after got=%b/%b/%h exp=1/0/0", dwait, ramREN, dload); end
    endtask

    task automatic test_dwrite;
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h7;
        @(negedge CLK);
        #1;
        checks++; if ({ramWEN, ramREN} !== 2'b10 || ramstore !== 32'h7 || ramaddr !== 32'h3100)
            begin errors++; $display("FAIL dwr_busy got=%b/%h/%h exp=10/7/3100", {ramWEN, ramREN}, ramstore, ramaddr); end
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL dwr_wait got=%b exp=1", dwait); end
        @(negedge CLK);
        ram_ready = 1'b1; ramload = 32'h1234; dREN = 1'b0; dWEN = 1'b0;
        #1;
        checks++; if (dwait !== 1'b0 || dload !== 32'h0 || ramWEN !== 1'b1)
            begin errors++; $display("FAIL dwr_done got=%b/%h/%b exp=0/0/1", dwait, dload, ramWEN); end
        @(negedge CLK);
        ram_ready = 1'b0;
        #1;
        checks++; if (dwait !== 1'b1 || ramWEN !== 1'b0) begin errors++; $display("FAIL dwr_after got=%b/%b exp=1/0", dwait, ramWEN); end
    endtask

    task automatic test_contention;
        logic exp_i;
        logic [31:0] data;
        iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h100;
        for (int i = 0; i < 10; i++) begin
            exp_i = (i % 5 == 4);
            data = 32'hA000 + i;
            @(negedge CLK);
            #1;
            checks++; if (ramaddr !== (exp_i ? 32'h200 : 32'h100))
                begin errors++; $display("FAIL cont_grant%0d got=%h exp=%h", i, ramaddr, exp_i ? 32'h200 : 32'h100); end
            ram_ready = 1'b1; ramload = data;
            #1;
            if (exp_i) begin
                checks++; if (iwait !== 1'b0 || iload !== data || dwait !== 1'b1)
                    begin errors++; $display("FAIL cont_i%0d got=%b/%h/%b exp=0/%h/1", i, iwait, iload, dwait, data); end
            end else begin
                checks++; if (dwait !== 1'b0 || dload !== data || iwait !== 1'b1)
                    begin errors++; $display("FAIL cont_d%0d got=%b/%h/%b exp=0/%h/1", i, dwait, dload, iwait, data); end
            end
            @(negedge CLK);
            ram_ready = 1'b0;
            if (i == 9) begin iREN = 1'b0; dREN = 1'b0; end
        end
    endtask

    task automatic test_input_change;
        @(negedge CLK);
        dREN = 1'b1; daddr = 32'h80;
        @(negedge CLK);
        #1;
        checks++; if (ramaddr !== 32'h80) begin errors++; $display("FAIL chg_addr0 got=%h exp=80", ramaddr); end
        daddr = 32'h84; dREN = 1'b0;
        @(negedge CLK);
        #1;
        checks++; if (ramaddr !== 32'h80 || ramREN !== 1'b1) begin errors++; $display("FAIL chg_addr1 got=%h/%b exp=80/1", ramaddr, ramREN); end
        ram_ready = 1'b1; ramload = 32'h55;
        #1;
        checks++; if (dwait !== 1'b0 || dload !== 32'h55) begin errors++; $display("FAIL chg_done got=%b/%h exp=0/55", dwait, dload); end
        @(negedge CLK);
        ram_ready = 1'b0;
        @(negedge CLK);
        #1;
        checks++; if ({ramREN, ramWEN} !== 2'b00 || dwait !== 1'b1)
            begin errors++; $display("FAIL chg_nogrant got=%b/%b exp=00/1", {ramREN, ramWEN}, dwait); end
    endtask

    task automatic test_idle_ready;
        ram_ready = 1'b1; ramload = 32'h99;
        #1;
        checks++; if (dwait !== 1'b1 || iwait !== 1'b1 || dload !== 32'h0 || iload !== 32'h0)
            begin errors++; $display("FAIL idle_rdy got=%b/%b/%h/%h exp=1/1/0/0", dwait, iwait, dload, iload); end
        @(negedge CLK);
        ram_ready = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL idle_rdy_en got=%b exp=0", ramREN); end
    endtask

    task automatic test_reset_mid;
        iREN = 1'b1; iaddr = 32'h300;
        @(negedge CLK);
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin errors++; $display("FAIL rmid_busy got=%b/%h exp=1/300", ramREN, ramaddr); end
        nRST = 1'b1;
        #1;
        checks++; if (ramREN !== 1'b0 || iwait !== 1'b1 || ramaddr !== 32'h0)
            begin errors++; $display("FAIL rmid_abort got=%b/%b/%h exp=0/1/0", ramREN, iwait, ramaddr); end
        @(negedge CLK);
        nRST = 1'b0; iaddr = 32'h304;
        @(negedge CLK);
        #1;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h304) begin errors++; $display("FAIL rmid_fresh got=%b/%h exp=1/304", ramREN, ramaddr); end
        ram_ready = 1'b1; ramload = 32'hCAFE; iREN = 1'b0;
        #1;
        checks++; if (iwait !== 1'b0 || iload !== 32'hCAFE || dwait !== 1'b1)
            begin errors++; $display("FAIL rmid_done got=%b/%h/%b exp=0/cafe/1", iwait, iload, dwait); end
        @(negedge CLK);
        ram_ready = 1'b0;
        #1;
        checks++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL rmid_after got=%b/%b exp=1/0", iwait, ramREN); end
    endtask

    initial begin
        test_reset;
        test_dread;
        test_dwrite;
        test_contention;
        test_input_change;
        test_idle_ready;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
